// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the write-back commit unit: write-back source and
// load-size encodings, the packed trace record, and the load-alignment helper.
package wb_commit_unit_pkg;

  // Write-back data source; encoding 2'b11 aliases the ALU result.
  typedef enum logic [1:0] {
    WBSEL_ALU     = 2'b00,
    WBSEL_LOAD    = 2'b01,
    WBSEL_PC8     = 2'b10,
    WBSEL_ALU_ALT = 2'b11
  } wb_sel_e;

  // Load access size; encoding 2'b11 aliases a full word.
  typedef enum logic [1:0] {
    LSIZE_WORD     = 2'b00,
    LSIZE_HALF     = 2'b01,
    LSIZE_BYTE     = 2'b10,
    LSIZE_WORD_ALT = 2'b11
  } load_size_e;

  // One retired-instruction record, 73 bits wide.
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wr_en;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
  } commit_trace_t;

  // Selects the addressed byte/half lane of a memory word and extends it.
  // Half-word accesses use only offset[1]; offset[0] is ignored for them.
  function automatic logic [31:0] load_align(input logic [31:0] word,
                                             input logic [1:0]  offset,
                                             input logic [1:0]  size,
                                             input logic        sign_ext);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (load_size_e'(size))
      LSIZE_HALF: result = {{16{sign_ext & lane_h[15]}}, lane_h};
      LSIZE_BYTE: result = {{24{sign_ext & lane_b[7]}}, lane_b};
      default:    result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_commit_unit_trace_fifo.sv
// commit_trace_fifo: synchronous FIFO of commit_trace_t records.
// Power-of-two depth, wrapping head/tail pointers, separate occupancy count.
// Head data reads as zero while empty; no push-to-pop bypass.
module commit_trace_fifo
  import wb_commit_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  commit_trace_t data_i,
  output commit_trace_t data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  commit_trace_t       mem_q [DEPTH];
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign data_o = empty_o ? '0 : mem_q[head_q];

  // Next-state for pointers and occupancy; pointers wrap at power-of-two depth.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + PW'(1);
    if (do_pop)  head_d = head_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state; reset empties the queue without draining it.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write on accepted push.
  // NOTE: the storage array is deliberately not reset; emptiness is tracked by
  // count_q and data_o is masked while empty, so stale contents are invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_d - PW'(1)] <= data_i;
  end

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: final write-back stage. Forms register-file write data,
// drives the GPR write port, owns HI/LO, and (with COMMIT_TRACE_EN defined)
// records every retired instruction into a trace FIFO that back-pressures WB.
// Build option: `define COMMIT_TRACE_EN to build the trace FIFO and port.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int TRACE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_Valid,
  input  logic        WB_Except,
  input  logic [31:0] WB_PC,
  input  logic [31:0] WB_ALUOut,
  input  logic [31:0] WB_DMOut,
  input  logic [31:0] WB_Hi,
  input  logic [31:0] WB_Lo,
  input  logic [1:0]  WB_WbSel,
  input  logic [4:0]  WB_Dst,
  input  logic        WB_RegWr,
  input  logic        WB_HiWr,
  input  logic        WB_LoWr,
  input  logic [1:0]  WB_LoadSize,
  input  logic        WB_LoadSign,
  output logic        RF_Wr,
  output logic [4:0]  RF_WrAddr,
  output logic [31:0] RF_WrData,
  output logic [31:0] Hi_Out,
  output logic [31:0] Lo_Out,
  output logic        WB_Stall,
  output logic        Trace_Valid,
  input  logic        Trace_Ready,
  output logic [31:0] Trace_PC,
  output logic [3:0]  Trace_WrEn,
  output logic [4:0]  Trace_WrNum,
  output logic [31:0] Trace_WrData
);

  logic        commit;
  logic [31:0] load_data;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  assign commit = WB_Valid & ~WB_Except & ~WB_Stall;

  // Write-back data select; PC+8 wraps naturally at 32 bits.
  always_comb begin
    load_data = load_align(WB_DMOut, WB_ALUOut[1:0], WB_LoadSize, WB_LoadSign);
    case (wb_sel_e'(WB_WbSel))
      WBSEL_LOAD: RF_WrData = load_data;
      WBSEL_PC8:  RF_WrData = WB_PC + 32'd8;
      default:    RF_WrData = WB_ALUOut;
    endcase
  end

  // r0 is hardwired to zero, so writes to it are dropped here.
  assign RF_Wr     = ~rst & commit & WB_RegWr & (WB_Dst != 5'd0);
  assign RF_WrAddr = WB_Dst;

  // HI/LO next state: independent write enables, both may fire together.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit & WB_HiWr) hi_d = WB_Hi;
    if (commit & WB_LoWr) lo_d = WB_Lo;
  end

  // HI/LO registers.
  // NOTE: sequential state uses non-blocking assignment only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign Hi_Out = hi_q;
  assign Lo_Out = lo_q;

`ifdef COMMIT_TRACE_EN
  commit_trace_t trace_in;
  commit_trace_t trace_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          trace_pop;

  assign trace_in = '{
    pc:      WB_PC,
    wr_en:   {4{RF_Wr}},
    wr_num:  WB_Dst,
    wr_data: RF_WrData
  };

  assign Trace_Valid  = ~fifo_empty;
  assign trace_pop    = Trace_Valid & Trace_Ready;
  assign Trace_PC     = trace_head.pc;
  assign Trace_WrEn   = trace_head.wr_en;
  assign Trace_WrNum  = trace_head.wr_num;
  assign Trace_WrData = trace_head.wr_data;

  // Only a full FIFO with no pop this cycle holds the pipeline.
  assign WB_Stall = ~rst & WB_Valid & ~WB_Except & fifo_full & ~trace_pop;

  commit_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (commit),
    .pop_i   (trace_pop),
    .data_i  (trace_in),
    .data_o  (trace_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
`else
  logic unused_trace;

  assign Trace_Valid  = 1'b0;
  assign Trace_PC     = '0;
  assign Trace_WrEn   = '0;
  assign Trace_WrNum  = '0;
  assign Trace_WrData = '0;
  assign WB_Stall     = 1'b0;
  assign unused_trace = ^{Trace_Ready, 32'(TRACE_DEPTH)};
`endif

endmodule
